display_select_ctrl: RTL
========================

Name: display_select_ctrl

Overview:
- Sequencer for the calculator's two-channel 3-digit display mux. Channel A is operand entry; channel B is the result.
- Generates the mux select from three sources:
  - a debounced user toggle button
  - an optional auto-alternate timer
  - a result-hold override that forces channel B on screen for a fixed time after each new result.
- Sits between the button/control logic and the display mux. Its display_select output drives the mux select directly.

Parameters:
- DEBOUNCE_CYCLES, 500000: consecutive stable cycles required to accept a button level change (10 ms at 50 MHz).
- AUTO_PERIOD, 50000000: dwell cycles per channel in auto-alternate mode.
- RESULT_HOLD, 100000000: cycles channel B is forced after a result_valid pulse.
- Counter widths are $clog2 of the respective parameter. All parameters are >= 2.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- btn_in  in  1  raw toggle button, active-high, asynchronous to clk, may bounce.
- auto_en  in  1  level; 1 enables auto-alternate between A and B.
- result_valid  in  1  single-cycle pulse; a new result is present on channel B.
- display_select  out  1  mux select: 0 = channel A, 1 = channel B.
- hold_active  out  1  1 while in the result-hold state.
- press_pulse  out  1  one-cycle debounced press event (also used internally).

Behaviour:
- Reset (asynchronous, active-high):
  - Takes effect immediately, with no clock edge required.
  - Clears the synchronizer flops, the debounced level (stable), and all counters.
  - Sets state = SHOW_A.
  - display_select = 0, hold_active = 0, press_pulse = 0.
- Button path:
  - Two-flop synchronizer on btn_in (sync1 -> sync2).
  - The debounce counter increments every cycle that sync2 != stable, and clears to 0 whenever sync2 == stable.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing, stable takes sync2 on that edge and the counter clears.
  - press_pulse is registered: high for exactly one cycle after stable goes 0->1. Release (1->0) generates no event.
  - Latency: if edge k first samples btn_in high and the input stays high, press_pulse is high after edge k+D+2 (D = DEBOUNCE_CYCLES). display_select reacts at edge k+D+3.
- FSM states:
  - SHOW_A: sel = 0, hold = 0.
  - SHOW_B: sel = 1, hold = 0.
  - HOLD_B: sel = 1, hold = 1.
- Transitions (evaluated each edge; priority result_valid > press_pulse > timer expiry):
  - result_valid from any state -> HOLD_B. The hold counter clears. A result_valid while already in HOLD_B restarts the hold count.
  - press_pulse: SHOW_A -> SHOW_B; SHOW_B -> SHOW_A; HOLD_B -> SHOW_A (cancels the hold).
  - Auto timer (SHOW_A/SHOW_B only):
    - Counts while auto_en = 1. On reaching AUTO_PERIOD-1 it toggles SHOW_A <-> SHOW_B and clears.
    - Clears when auto_en = 0 and on every state change, whatever the cause.
    - Each channel therefore dwells exactly AUTO_PERIOD cycles.
  - Hold counter (HOLD_B only): on reaching RESULT_HOLD-1 -> SHOW_A. auto_en is ignored in HOLD_B, and the auto timer stays at 0.
- Outputs display_select and hold_active are registered and decoded from the state register, with no combinational path from inputs.
- Boundary cases:
  - Simultaneous result_valid and press_pulse: enter or restart HOLD_B; the press is discarded.
  - Simultaneous press_pulse and auto expiry: a single toggle only, never a double toggle.
  - Bounce shorter than D cycles: no press_pulse, display unchanged.
  - Button held across reset release: stable = 0 after reset, so exactly one press_pulse follows at D+3 edges after reset deasserts.
  - Reset asserted mid-hold or mid-debounce: all progress is lost and the block returns to SHOW_A.

Test Plan (DEBOUNCE_CYCLES=4, AUTO_PERIOD=8, RESULT_HOLD=10):
1. Reset: drive to SHOW_B, then assert reset between clock edges -> display_select=0 and hold_active=0 before the next edge; after release, outputs stay 0 with no inputs.
2. Bounce: btn_in toggles every 2 cycles for 12 cycles, then holds high -> exactly one press_pulse, 6 edges after the first sample of the final high level; display_select 0->1 one edge later. Release with bounce -> no further pulses.
3. Auto: auto_en=1, idle -> display_select is 0 for 8 cycles, 1 for 8, repeating. Drop auto_en at count 5, raise it 3 cycles later -> a full 8-cycle dwell restarts.
4. Hold: result_valid in SHOW_A -> next edge sel=1, hold=1; after 10 cycles, sel=0, hold=0. A second result_valid 5 cycles into the hold -> the hold ends 10 cycles after that second pulse (15 total).
5. Priority: result_valid and press_pulse in the same cycle -> HOLD_B. Then a press during the hold -> SHOW_A. Press and auto expiry in the same cycle -> exactly one toggle.
6. Held button through reset: btn_in=1 across reset deassert -> one press_pulse 7 edges after release, then no more while held.

Source files
------------

// File: rtl/display_select_ctrl.sv
// Display mux select sequencer for the two-channel calculator display.
// Combines a debounced toggle button, optional auto-alternate, and a result-hold override of channel B.
module display_select_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int AUTO_PERIOD     = 50000000,
  parameter int RESULT_HOLD     = 100000000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  input  logic auto_en,
  input  logic result_valid,
  output logic display_select,
  output logic hold_active,
  output logic press_pulse
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int AW = $clog2(AUTO_PERIOD);
  localparam int HW = $clog2(RESULT_HOLD);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [AW-1:0] AUTO_LAST = AW'(AUTO_PERIOD - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(RESULT_HOLD - 1);

  typedef enum logic [1:0] {
    SHOW_A = 2'd0,
    SHOW_B = 2'd1,
    HOLD_B = 2'd2
  } state_t;

  state_t state, next_state;
  logic sync1, sync2, stable, stable_q;
  logic [DW-1:0] deb_cnt;
  logic [AW-1:0] auto_cnt, auto_next;
  logic [HW-1:0] hold_cnt, hold_next;

  // Button path: synchronizer, debounce, and registered rising-edge event.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1       <= 1'b0;
      sync2       <= 1'b0;
      stable      <= 1'b0;
      stable_q    <= 1'b0;
      deb_cnt     <= '0;
      press_pulse <= 1'b0;
    end else begin
      sync1    <= btn_in;
      sync2    <= sync1;
      stable_q <= stable;
      press_pulse <= stable & ~stable_q;
      if (sync2 == stable) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_LAST) begin
        stable  <= sync2;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + DW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= SHOW_A;
      auto_cnt       <= '0;
      hold_cnt       <= '0;
      display_select <= 1'b0;
      hold_active    <= 1'b0;
    end else begin
      state          <= next_state;
      auto_cnt       <= auto_next;
      hold_cnt       <= hold_next;
      display_select <= (next_state != SHOW_A);
      hold_active    <= (next_state == HOLD_B);
    end
  end

  // Counters default to zero so any state change clears both timers.
  always_comb begin
    next_state = state;
    auto_next  = '0;
    hold_next  = '0;
    if (result_valid) begin
      next_state = HOLD_B;
    end else if (press_pulse) begin
      next_state = (state == SHOW_A) ? SHOW_B : SHOW_A;
    end else begin
      unique case (state)
        SHOW_A, SHOW_B: begin
          if (auto_en) begin
            if (auto_cnt == AUTO_LAST) begin
              next_state = (state == SHOW_A) ? SHOW_B : SHOW_A;
            end else begin
              auto_next = auto_cnt + AW'(1);
            end
          end
        end
        HOLD_B: begin
          if (hold_cnt == HOLD_LAST) begin
            next_state = SHOW_A;
          end else begin
            hold_next = hold_cnt + HW'(1);
          end
        end
        default: next_state = SHOW_A;
      endcase
    end
  end
endmodule
